// File: rtl/uart_rx_ovs_if.sv
// Result bundle of the oversampling UART receiver: received word, completion
// pulse, error flags and busy status.
interface uart_rx_ovs_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              rx_done;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output data,
    output rx_done,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input data,
    input rx_done,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver with 5-sample majority vote per bit,
// optional parity, 1 or 2 checked stop bits and a per-frame latched baud rate.
module uart_rx_ovs #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int DATA_W      = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic          sysclk,
  input  logic          rst,
  input  logic [2:0]    baud_set,
  input  logic          uart_rx,
  uart_rx_ovs_if.master rx_if
);

  localparam int DIV_4800   = CLK_FREQ_HZ / (4800 * 16);
  localparam int DIV_9600   = CLK_FREQ_HZ / (9600 * 16);
  localparam int DIV_19200  = CLK_FREQ_HZ / (19200 * 16);
  localparam int DIV_38400  = CLK_FREQ_HZ / (38400 * 16);
  localparam int DIV_57600  = CLK_FREQ_HZ / (57600 * 16);
  localparam int DIV_115200 = CLK_FREQ_HZ / (115200 * 16);
  localparam int CNT_W      = $clog2(DIV_4800 + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Terminal count (divisor - 1) of the 16x tick counter for a baud select.
  function automatic logic [CNT_W-1:0] div_term(input logic [2:0] sel);
    case (sel)
      3'd0:    div_term = CNT_W'(DIV_4800 - 1);
      3'd1:    div_term = CNT_W'(DIV_9600 - 1);
      3'd2:    div_term = CNT_W'(DIV_19200 - 1);
      3'd3:    div_term = CNT_W'(DIV_38400 - 1);
      3'd4:    div_term = CNT_W'(DIV_57600 - 1);
      default: div_term = CNT_W'(DIV_115200 - 1);
    endcase
  endfunction

  // Parity check: odd mode wants XOR(data, p)=1, even mode wants 0.
  function automatic logic parity_fail(input logic [DATA_W-1:0] d, input logic p);
    if (PARITY == 1) begin
      parity_fail = ~(^d ^ p);
    end else if (PARITY == 2) begin
      parity_fail = ^d ^ p;
    end else begin
      parity_fail = 1'b0;
    end
  endfunction

  logic              sync1_r, rx_s, rx_q;
  logic [2:0]        state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, term_r;
  logic [3:0]        tidx_r, bit_r;
  logic [2:0]        ones_r;
  logic [DATA_W-1:0] shift_r, data_r;
  logic              perr_acc_r, ferr_acc_r;
  logic              rx_done_r, perr_r, ferr_r, busy_r;

  logic start_edge_s, tick_s, samp_s, decide_s, vote_s, last_data_s, last_stop_s;

  // Two-flop synchroniser plus one-cycle-delayed copy for falling-edge detection.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_r <= uart_rx;
      rx_s    <= sync1_r;
      rx_q    <= rx_s;
    end
  end

  // A line held low since IDLE entry has rx_q=0, so no start edge is seen until it rises again.
  assign start_edge_s = (state_r == ST_IDLE) && rx_q && !rx_s;
  assign tick_s       = (state_r != ST_IDLE) && (cnt_r == term_r);
  assign samp_s       = tick_s && (tidx_r >= 4'd6) && (tidx_r <= 4'd10);
  assign decide_s     = tick_s && (tidx_r == 4'd10);
  assign vote_s       = (ones_r + {2'b00, rx_s}) >= 3'd3;
  assign last_data_s  = (bit_r == 4'(DATA_W - 1));
  assign last_stop_s  = (bit_r == 4'(STOP_BITS - 1));

  // Next-state logic; every bit decision is taken at tick index 10.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) state_nxt_s = ST_START;
        else              state_nxt_s = ST_IDLE;
      end
      ST_START: begin
        if (decide_s) state_nxt_s = vote_s ? ST_IDLE : ST_DATA;
        else          state_nxt_s = ST_START;
      end
      ST_DATA: begin
        if (decide_s && last_data_s) state_nxt_s = (PARITY != 0) ? ST_PAR : ST_STOP;
        else                         state_nxt_s = ST_DATA;
      end
      ST_PAR: begin
        if (decide_s) state_nxt_s = ST_STOP;
        else          state_nxt_s = ST_PAR;
      end
      ST_STOP: begin
        if (decide_s && last_stop_s) state_nxt_s = ST_IDLE;
        else                         state_nxt_s = ST_STOP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Tick generation, free-running tick index and majority-vote accumulator.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      term_r <= '0;
      tidx_r <= 4'd0;
      ones_r <= 3'd0;
    end else if (start_edge_s) begin
      cnt_r  <= '0;
      term_r <= div_term(baud_set);
      tidx_r <= 4'd0;
      ones_r <= 3'd0;
    end else if (state_r != ST_IDLE) begin
      if (tick_s) begin
        cnt_r  <= '0;
        tidx_r <= tidx_r + 4'd1;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
      end
      if (decide_s)    ones_r <= 3'd0;
      else if (samp_s) ones_r <= ones_r + {2'b00, rx_s};
    end else begin
      cnt_r  <= '0;
      tidx_r <= 4'd0;
      ones_r <= 3'd0;
    end
  end

  // Frame datapath; results are published only at the final stop-bit decision.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      bit_r      <= 4'd0;
      shift_r    <= '0;
      perr_acc_r <= 1'b0;
      ferr_acc_r <= 1'b0;
      data_r     <= '0;
      perr_r     <= 1'b0;
      ferr_r     <= 1'b0;
      rx_done_r  <= 1'b0;
    end else begin
      rx_done_r <= 1'b0;
      if (decide_s) begin
        case (state_r)
          ST_START: begin
            bit_r      <= 4'd0;
            perr_acc_r <= 1'b0;
            ferr_acc_r <= 1'b0;
          end
          ST_DATA: begin
            shift_r <= {vote_s, shift_r[DATA_W-1:1]};
            bit_r   <= last_data_s ? 4'd0 : bit_r + 4'd1;
          end
          ST_PAR: perr_acc_r <= parity_fail(shift_r, vote_s);
          ST_STOP: begin
            if (last_stop_s) begin
              data_r    <= shift_r;
              perr_r    <= perr_acc_r;
              ferr_r    <= ferr_acc_r | ~vote_s;
              rx_done_r <= 1'b1;
            end else begin
              ferr_acc_r <= ferr_acc_r | ~vote_s;
              bit_r      <= bit_r + 4'd1;
            end
          end
          default: bit_r <= 4'd0;
        endcase
      end
    end
  end

  assign rx_if.data       = data_r;
  assign rx_if.rx_done    = rx_done_r;
  assign rx_if.parity_err = perr_r;
  assign rx_if.frame_err  = ferr_r;
  assign rx_if.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: three instances (no parity, even parity,
// two stop bits) each with its own serial line and baud select.
module tb_uart_rx_ovs;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       line0, line1, line2;
  logic [2:0] baud0, baud1, baud2;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [9:0] sb [3][$];

  uart_rx_ovs_if #(.DATA_W(8)) if0 ();
  uart_rx_ovs_if #(.DATA_W(8)) if1 ();
  uart_rx_ovs_if #(.DATA_W(8)) if2 ();

  uart_rx_ovs #(.CLK_FREQ_HZ(50000000), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .sysclk(sysclk), .rst(rst), .baud_set(baud0), .uart_rx(line0), .rx_if(if0));
  uart_rx_ovs #(.CLK_FREQ_HZ(50000000), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) dut1 (
    .sysclk(sysclk), .rst(rst), .baud_set(baud1), .uart_rx(line1), .rx_if(if1));
  uart_rx_ovs #(.CLK_FREQ_HZ(50000000), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .sysclk(sysclk), .rst(rst), .baud_set(baud2), .uart_rx(line2), .rx_if(if2));

  always #10 sysclk = ~sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0:       line0 = v;
      1:       line1 = v;
      default: line2 = v;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge sysclk);
  endtask

  // Drives one frame bit-by-bit; optional single inverted sample window at tick 8 of data bits
  // and an optional baud_set change on dut0 at the start of bit chg_at.
  task automatic send_frame(input int idx, input logic [7:0] d, input int pmode, input logic pflip,
                            input int nstop, input logic [1:0] stops, input int div,
                            input logic noise, input int chg_at, input logic [2:0] chg_val);
    logic [15:0] bits;
    int          n;
    logic        v, fe, pe;
    bits    = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    pe = 1'b0;
    if (pmode != 0) begin
      bits[n] = ((pmode == 2) ? ^d : ~^d) ^ pflip;
      pe = pflip;
      n++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[n] = stops[s];
      n++;
    end
    fe = (nstop == 2) ? ~(stops[0] & stops[1]) : ~stops[0];
    sb[idx].push_back({fe, pe, d});
    for (int b = 0; b < n; b++) begin
      if (b == chg_at) baud0 = chg_val;
      for (int c = 0; c < 16 * div; c++) begin
        v = bits[b];
        if (noise && b >= 1 && b <= 8 && c >= 8 * div + div / 2 && c < 9 * div + div / 2) v = ~v;
        @(negedge sysclk);
        set_line(idx, v);
      end
    end
  endtask

  task automatic wait_drain(input int idx, input int budget);
    for (int i = 0; i < budget && sb[idx].size() != 0; i++) @(negedge sysclk);
    check_val($sformatf("drain%0d", idx), 32'(sb[idx].size()), 32'd0);
  endtask

  task automatic mon_one(input int idx, input logic done, input logic [7:0] d,
                         input logic pe, input logic fe);
    logic [9:0] e;
    if (done) begin
      if (sb[idx].size() == 0) begin
        check_val($sformatf("spurious_done%0d", idx), 32'(done), 32'd0);
      end else begin
        e = sb[idx].pop_front();
        check_val($sformatf("data%0d", idx), 32'(d), 32'(e[7:0]));
        check_val($sformatf("parity_err%0d", idx), 32'(pe), 32'(e[8]));
        check_val($sformatf("frame_err%0d", idx), 32'(fe), 32'(e[9]));
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    line0 = 1'b1;
    line1 = 1'b1;
    line2 = 1'b1;
    baud0 = 3'd5;
    baud1 = 3'd5;
    baud2 = 3'd5;
    wait_cyc(5);
    check_val("rst_data0", 32'(if0.data), 32'd0);
    check_val("rst_done0", 32'(if0.rx_done), 32'd0);
    check_val("rst_perr1", 32'(if1.parity_err), 32'd0);
    check_val("rst_ferr2", 32'(if2.frame_err), 32'd0);
    check_val("rst_busy0", 32'(if0.busy), 32'd0);
    rst = 1'b0;
    wait_cyc(5);

    fork
      forever begin
        @(negedge sysclk);
        if (!rst) begin
          mon_one(0, if0.rx_done, if0.data, if0.parity_err, if0.frame_err);
          mon_one(1, if1.rx_done, if1.data, if1.parity_err, if1.frame_err);
          mon_one(2, if2.rx_done, if2.data, if2.parity_err, if2.frame_err);
        end
      end
    join_none

    fork
      begin
        // nominal frame, then a short glitch, then a noisy frame, then a mid-frame baud change
        send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11, 27, 1'b0, -1, 3'd5);
        wait_drain(0, 1000);
        wait_cyc(100);
        set_line(0, 1'b0);
        wait_cyc(54);
        set_line(0, 1'b1);
        wait_cyc(81);
        check_val("glitch_busy_hi", 32'(if0.busy), 32'd1);
        wait_cyc(243);
        check_val("glitch_busy_lo", 32'(if0.busy), 32'd0);
        wait_cyc(200);
        send_frame(0, 8'h5A, 0, 1'b0, 1, 2'b11, 27, 1'b1, -1, 3'd5);
        wait_drain(0, 1000);
        send_frame(0, 8'h3E, 0, 1'b0, 1, 2'b11, 27, 1'b0, 4, 3'd1);
        wait_drain(0, 1000);
        send_frame(0, 8'h81, 0, 1'b0, 1, 2'b11, 325, 1'b0, -1, 3'd1);
        wait_drain(0, 8000);
      end
      begin
        send_frame(1, 8'h3C, 2, 1'b0, 1, 2'b11, 27, 1'b0, -1, 3'd5);
        wait_drain(1, 1000);
        send_frame(1, 8'h3C, 2, 1'b1, 1, 2'b11, 27, 1'b0, -1, 3'd5);
        wait_drain(1, 1000);
        // second stop low, then the line stays low for three frame times
        send_frame(2, 8'hFF, 0, 1'b0, 2, 2'b01, 27, 1'b0, -1, 3'd5);
        wait_drain(2, 1000);
        wait_cyc(3 * 11 * 16 * 27);
        check_val("break_busy2", 32'(if2.busy), 32'd0);
        set_line(2, 1'b1);
        wait_cyc(600);
        check_val("break_release_busy2", 32'(if2.busy), 32'd0);
        send_frame(2, 8'h55, 0, 1'b0, 2, 2'b11, 27, 1'b0, -1, 3'd5);
        wait_drain(2, 1000);
      end
    join

    // reset in the middle of a frame aborts it
    baud0 = 3'd5;
    wait_cyc(100);
    for (int c = 0; c < 432; c++) begin @(negedge sysclk); line0 = 1'b0; end
    for (int c = 0; c < 432; c++) begin @(negedge sysclk); line0 = 1'b1; end
    for (int c = 0; c < 200; c++) begin @(negedge sysclk); line0 = 1'b0; end
    check_val("pre_rst_busy0", 32'(if0.busy), 32'd1);
    line0 = 1'b1;
    rst   = 1'b1;
    wait_cyc(3);
    check_val("mid_rst_busy0", 32'(if0.busy), 32'd0);
    check_val("mid_rst_data0", 32'(if0.data), 32'd0);
    wait_cyc(7);
    rst = 1'b0;
    wait_cyc(12 * 432);
    check_val("post_rst_busy0", 32'(if0.busy), 32'd0);
    send_frame(0, 8'hC3, 0, 1'b0, 1, 2'b11, 27, 1'b0, -1, 3'd5);
    wait_drain(0, 1000);
    wait_cyc(300);

    for (int i = 0; i < 3; i++) check_val($sformatf("leftover%0d", i), 32'(sb[i].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
